// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared FSM state type, wait counter width and address LSB helper for the APB register bank
package apb_reg_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int WAIT_W = 4;
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/apb_slv_fsm.sv
// apb_slv_fsm: APB slave phase tracker with a saturating wait-state counter
module apb_slv_fsm
  import apb_reg_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel_i,
  input  logic penable_i,
  output logic access_o,
  output logic pready_o
);
  apb_state_e state_q, state_d, phase;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic done;
  // ACCESS only continues while the master keeps psel and penable high; anything else aborts
  assign phase = (state_q == ACCESS && psel_i && penable_i) ? ACCESS :
                 (psel_i && !penable_i) ? SETUP : IDLE;
  assign done = phase == ACCESS && cnt_q == WAIT_W'(WAIT_STATES) && !rst;
  assign state_d = (phase == SETUP || (phase == ACCESS && !done)) ? ACCESS : IDLE;
  assign cnt_d = (phase == ACCESS && !done) ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
  assign access_o = done;
  assign pready_o = done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB register bank, NUM_REGS-1 RW control words plus one RO status word.
// Define APB_REG_PSTRB_EN to add the pstrb byte-lane write enable port.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic pclk,
  input  logic preset,
  input  logic [31:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
`ifdef APB_REG_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic pready,
  output logic pslverr,
  input  logic [DATA_W-1:0] sts_in,
  output logic [(NUM_REGS-1)*DATA_W-1:0] ctl_out
);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int STS = NUM_REGS - 1;
  localparam logic [31:0] ALIGN_MASK = (32'd1 << ADDR_LSB) - 32'd1;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] bmask, wr_d;
  logic [IDX_W-1:0] idx;
  logic access, err;
  apb_slv_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk(pclk),
    .rst(preset),
    .psel_i(psel),
    .penable_i(penable),
    .access_o(access),
    .pready_o(pready)
  );
  // the shifted compare also catches any set address bit above the decoded index
  assign idx = paddr[ADDR_LSB +: IDX_W];
  assign err = (paddr & ALIGN_MASK) != 32'd0 || (paddr >> ADDR_LSB) >= 32'(NUM_REGS) ||
               (pwrite && idx == IDX_W'(STS));
  always_comb begin
    bmask = '1;
`ifdef APB_REG_PSTRB_EN
    for (int b = 0; b < DATA_W / 8; b++) bmask[b*8 +: 8] = {8{pstrb[b]}};
`endif
  end
  assign wr_d = (regs_q[idx] & ~bmask) | (pwdata & bmask);
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= (r == STS) ? '0 : RST_VAL[r*DATA_W +: DATA_W];
    end else begin
      regs_q[STS] <= sts_in;
      for (int r = 0; r < STS; r++)
        if (access && pwrite && !err && idx == IDX_W'(r)) regs_q[r] <= wr_d;
    end
  end
  assign prdata = (pready && !pwrite && !err) ? regs_q[idx] : '0;
  assign pslverr = pready && err;
  genvar i;
  for (i = 0; i < NUM_REGS - 1; i++) begin : g_ctl
    assign ctl_out[i*DATA_W +: DATA_W] = regs_q[i];
  end
endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: directed self-checking bench for apb_reg_bank (WAIT_STATES=2, non-zero reset values)
module tb_apb_reg_bank;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int WS = 2;
  localparam logic [NR*DW-1:0] RV = {32'hDEAD0007, 32'h06060606, 32'h05050505, 32'h04040404,
                                     32'h03030303, 32'h02020202, 32'h01010101, 32'hA5A5A500};
  logic pclk = 0, preset = 1;
  logic [31:0] paddr = '0;
  logic [DW-1:0] pwdata = '0, prdata, sts_in = '0;
  logic psel = 0, penable = 0, pwrite = 0, pready, pslverr;
  logic [DW/8-1:0] pstrb = '1;
  logic [(NR-1)*DW-1:0] ctl_out;
  logic [31:0] exp_rst [NR] = '{32'hA5A5A500, 32'h01010101, 32'h02020202, 32'h03030303,
                                32'h04040404, 32'h05050505, 32'h06060606, 32'h00000000};
  logic [31:0] rd;
  logic er;
  int waits;
  int n_chk = 0, n_err = 0;
  always #5 pclk = ~pclk;
  apb_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(WS), .RST_VAL(RV)) dut (
    .pclk(pclk),
    .preset(preset),
    .paddr(paddr),
    .pwdata(pwdata),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
`ifdef APB_REG_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .sts_in(sts_in),
    .ctl_out(ctl_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output logic e, output int w);
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1;
    w = 0;
    @(negedge pclk);
    while (!pready && w < 40) begin
      w++;
      @(negedge pclk);
    end
    if (!pready) check("timeout", pready, 1);
    r = prdata;
    e = pslverr;
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
    xfer(0, a, 32'h0, 4'hF, rd, er, waits);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, er, exp_err);
  endtask
  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err);
    xfer(1, a, d, s, rd, er, waits);
    check({tag, "_err"}, er, exp_err);
    check({tag, "_prdata"}, rd, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    psel = 1; penable = 1; pwrite = 1; paddr = 32'h4; pwdata = 32'hFFFFFFFF;
    repeat (2) @(negedge pclk);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    @(posedge pclk); #1;
    preset = 0; psel = 0; penable = 0; pwrite = 0;
    for (int i = 0; i < NR; i++) rd_chk($sformatf("rst_r%0d", i), 32'(i * 4), exp_rst[i], 0);
    check("rst_ctl0", ctl_out[31:0], 32'hA5A5A500);
    xfer(1, 32'h4, 32'hCAFE1234, 4'hF, rd, er, waits);
    check("wr4_waits", waits, WS);
    check("wr4_err", er, 0);
    check("wr4_prdata", rd, 0);
    rd_chk("rb4", 32'h4, 32'hCAFE1234, 0);
    check("rb4_waits", waits, WS);
    check("ctl1", ctl_out[63:32], 32'hCAFE1234);
    wr_chk("wr_sts", 32'h1C, 32'h55, 4'hF, 1);
    rd_chk("rd_20", 32'h20, 32'h0, 1);
    rd_chk("sts_keep", 32'h1C, 32'h0, 0);
    wr_chk("wr_20", 32'h20, 32'hBAD, 4'hF, 1);
    rd_chk("r0_keep", 32'h0, 32'hA5A5A500, 0);
    check("ctl6_keep", ctl_out[223:192], 32'h06060606);
    sts_in = 32'hFACE5678;
    rd_chk("sts", 32'h1C, 32'hFACE5678, 0);
    rd_chk("unal", 32'h2, 32'h0, 1);
    rd_chk("hi_addr", 32'h80000004, 32'h0, 1);
    wr_chk("unal_w", 32'h9, 32'h77, 4'hF, 1);
    rd_chk("r2_keep", 32'h8, 32'h02020202, 0);
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h8; pwdata = 32'h99999999;
    @(posedge pclk); #1;
    penable = 1;
    @(negedge pclk);
    check("abort_pready", pready, 0);
    @(posedge pclk); #1;
    psel = 0;
    @(negedge pclk);
    check("abort_idle_pready", pready, 0);
    @(posedge pclk); #1;
    penable = 0; pwrite = 0;
    rd_chk("abort_keep", 32'h8, 32'h02020202, 0);
`ifdef APB_REG_PSTRB_EN
    wr_chk("s_full", 32'h0, 32'h11223344, 4'hF, 0);
    wr_chk("s_part", 32'h0, 32'hAABBCCDD, 4'b0101, 0);
    rd_chk("s_rd", 32'h0, 32'h11BB33DD, 0);
    wr_chk("s_zero", 32'h0, 32'hFFFFFFFF, 4'h0, 0);
    rd_chk("s_zero_rd", 32'h0, 32'h11BB33DD, 0);
`else
    wr_chk("full_w", 32'h0, 32'hAABBCCDD, 4'b0101, 0);
    rd_chk("full_rd", 32'h0, 32'hAABBCCDD, 0);
`endif
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'hC; pwdata = 32'h12345678;
    @(posedge pclk); #1;
    penable = 1;
    @(negedge pclk);
    check("rw_a1_pready", pready, 0);
    @(posedge pclk); #1;
    preset = 1;
    @(negedge pclk);
    check("rw_rst_pready", pready, 0);
    check("rw_rst_prdata", prdata, 0);
    @(posedge pclk); #1;
    preset = 0;
    @(negedge pclk);
    check("rw_post_pready", pready, 0);
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
    rd_chk("rw_keep", 32'hC, 32'h03030303, 0);
    rd_chk("rw_r1", 32'h4, 32'h01010101, 0);
    rd_chk("rw_r0", 32'h0, 32'hA5A5A500, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus and register width (multiple of 8, 8..64).
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning register count (2..64), word-addressed at offsets 0, DATA_W/8, ...
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning extra ACCESS cycles before pready (0..15).
REQ-004 SHALL have parameter RST_VAL, default all-zero NUM_REGS*DATA_W vector, meaning per-register reset value.
REQ-005 SHALL have ports: pclk  input  1  clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have ports: preset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: paddr input 32 byte address; pwdata input DATA_W; psel input 1; penable input 1; pwrite input 1.
REQ-008 SHALL have ports: prdata output DATA_W read data; pready output 1; pslverr output 1.
REQ-009 SHALL have ports: sts_in input DATA_W hardware status; ctl_out output (NUM_REGS-1)*DATA_W, concatenated RW registers 0..NUM_REGS-2.

Function
REQ-010 SHALL implement FSM IDLE -> SETUP (psel & !penable) -> ACCESS (psel & penable) -> IDLE on pready=1.
REQ-011 SHALL hold ACCESS with pready=0 for exactly WAIT_STATES cycles, then assert pready for one cycle; WAIT_STATES=0 gives pready=1 in the first ACCESS cycle.
REQ-012 SHALL commit writes and sample reads only in the pready=1 cycle; earlier ACCESS cycles have no side effect.
REQ-013 SHALL drive prdata = selected register when pready=1 and !pwrite, else all-zero (no tristate).
REQ-014 SHALL treat registers 0..NUM_REGS-2 as RW; register NUM_REGS-1 as RO STATUS, loaded from sts_in every cycle.
REQ-015 SHALL assert pslverr with pready for: address beyond last register, address not word-aligned, or write to STATUS; the transfer then has no effect and prdata=0.
REQ-016 SHALL decode only paddr bits needed for NUM_REGS words; any set higher bit is out-of-range (REQ-015).
REQ-017 SHALL abort to IDLE with no commit if psel drops during ACCESS before pready.
REQ-018 SHALL treat penable without psel as IDLE; back-to-back transfers re-enter SETUP directly from the completion cycle.
REQ-019 SHALL reset the wait counter on every entry to ACCESS; counter saturates, never wraps.

Reset
REQ-020 SHALL, with preset=1 at a pclk edge, load register i with RST_VAL slice i, STATUS with 0, FSM to IDLE, counter to 0.
REQ-021 SHALL hold pready=0, pslverr=0, prdata=0 during reset; reset mid-transfer discards the transfer.

Configuration
REQ-022 SHALL honour macro APB_REG_PSTRB_EN: defined adds input pstrb (DATA_W/8) and writes only byte lanes with pstrb=1; pstrb=0 write completes with no change and no error.
REQ-023 SHALL, without APB_REG_PSTRB_EN, have no pstrb port and write full words.

Structure
REQ-024 SHALL place FSM state enum, ADDR_LSB computation, and WAIT_W counter width constant in shared package apb_reg_pkg.
REQ-025 SHALL isolate FSM plus wait counter in sub-module apb_slv_fsm (outputs: access strobe, pready); register array and decode in apb_reg_bank.

Verification
REQ-026 SHALL cover: reset, read all offsets -> each equals RST_VAL slice, STATUS=0, pslverr=0.
REQ-027 SHALL cover: WAIT_STATES=2, write 0xCAFE1234 to 0x4 -> pready high on 3rd ACCESS cycle, readback 0xCAFE1234.
REQ-028 SHALL cover: write to STATUS (0x1C, NUM_REGS=8) and read 0x20 -> pslverr=1 both, no register change.
REQ-029 SHALL cover: sts_in=0xFACE5678, read 0x1C -> prdata=0xFACE5678; unaligned read 0x2 -> pslverr=1, prdata=0.
REQ-030 SHALL cover: APB_REG_PSTRB_EN, reg 0 = 0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> reads 0x11BB33DD.
REQ-031 SHALL cover: preset asserted in the last wait cycle of a write -> register keeps RST_VAL, FSM IDLE next cycle.
